// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg: shared FSM states and sizing constants for the FIFO-fed UART transmitter.
package fifo_uart_tx_pkg;
    localparam int CLKS_PER_BIT_DEF = 16;
    localparam int DATA_W = 8;
    typedef enum logic [2:0] {IDLE, RD, WAIT, START, DATA, PARITY, STOP} state_e;
endpackage

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: read port between an upstream FIFO (master) and the transmitter (slave).
interface fifo_uart_tx_if;
    import fifo_uart_tx_pkg::*;
    logic              fifo_empty_n;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rd;
    modport master (output fifo_empty_n, fifo_data, input fifo_rd);
    modport slave  (input fifo_empty_n, fifo_data, output fifo_rd);
endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period down-counter; load restarts a period, tick marks its last cycle.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick,
    output logic tick_next
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = load ? CW'(CLKS_PER_BIT - 1) : (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    end
    assign tick      = cnt_q == '0;
    assign tick_next = cnt_q == CW'(1);
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an upstream FIFO and sends them as UART frames, LSB first,
// with optional even parity. Every output is a flop computed from the next state.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    fifo_uart_tx_if.slave fifo,
    output logic          txd,
    output logic          busy,
    output logic          frame_done
);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [2:0]        idx_q, idx_d;
    logic              par_q, par_d, txd_q, txd_d, rd_q, rd_d, busy_q, busy_d, done_q, done_d;
    logic              tick, tick_next, load;

    // STOP's final tick leaves the counter parked at zero while idle.
    assign load = state_q == WAIT || (tick && (state_q == START || state_q == DATA || state_q == PARITY));

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk(clk), .rst(rst), .load(load), .tick(tick), .tick_next(tick_next)
    );

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        par_d   = par_q;
        case (state_q)
            IDLE:    if (enable && fifo.fifo_empty_n) state_d = RD;
            RD:      state_d = WAIT;
            WAIT: begin
                state_d = START;
                sh_d    = fifo.fifo_data;
                par_d   = ^fifo.fifo_data;
            end
            START:   if (tick) state_d = DATA;
            DATA: if (tick) begin
                sh_d  = sh_q >> 1;
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
            end
            PARITY:  if (tick) state_d = STOP;
            STOP:    if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        txd_d  = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : state_d == PARITY ? par_d : 1'b1;
        rd_d   = state_d == RD;
        busy_d = state_d != IDLE;
        // Raised one cycle early so the registered pulse lands on the last STOP cycle.
        done_d = state_q == STOP && tick_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign fifo.fifo_rd = rd_q;
    assign txd          = txd_q;
    assign busy         = busy_q;
    assign frame_done   = done_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: two transmitters (no parity / even parity) fed by FIFO models; a per-instance
// monitor decodes txd and checks each frame against a scoreboard of expected bytes.
module tb_fifo_uart_tx;
    import fifo_uart_tx_pkg::*;
    localparam int CPB = 4;
    typedef struct {logic [7:0] d; logic p; int gap;} item_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v[2], en[2], txd[2], busy[2], fdone[2], rd_w[2];
    logic [7:0] fq[2][$];
    item_t      exp_q[2][$];
    int         rd_cnt[2], fd_cnt[2];
    int         n_chk, n_pass;
    bit         mon_on;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen
        fifo_uart_tx_if ffif();
        fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(g == 1)) dut (
            .clk(clk), .rst(rst_v[g]), .enable(en[g]), .fifo(ffif),
            .txd(txd[g]), .busy(busy[g]), .frame_done(fdone[g])
        );
        assign rd_w[g] = ffif.fifo_rd;

        // FIFO with registered read data: a read strobe presents the byte on the next cycle.
        always @(posedge clk) if (rd_w[g] === 1'b1) begin
            chk($sformatf("dut%0d read while empty", g), fq[g].size() != 0, 1);
            if (fq[g].size() != 0) ffif.fifo_data <= fq[g].pop_front();
            rd_cnt[g]++;
        end
        always @(negedge clk) ffif.fifo_empty_n = fq[g].size() != 0;
        always @(posedge clk) if (fdone[g] === 1'b1) fd_cnt[g]++;

        initial begin : mon
            int gap, nb;
            item_t it;
            logic [10:0] bits;
            logic lvl;
            bit abort, fdok;
            gap = 0;
            forever begin
                @(negedge clk);
                if (!mon_on || rst_v[g]) begin gap = 0; continue; end
                if (txd[g] === 1'b1) begin gap++; continue; end
                chk($sformatf("dut%0d frame expected", g), exp_q[g].size() != 0, 1);
                if (exp_q[g].size() != 0) it = exp_q[g].pop_front();
                else begin it.d = 8'h00; it.p = 1'b0; it.gap = -1; end
                if (it.gap >= 0) chk($sformatf("dut%0d idle gap before %02h", g, it.d), gap, it.gap);
                bits = g ? {1'b1, it.p, it.d, 1'b0} : {2'b01, it.d, 1'b0};
                nb = g ? 11 : 10;
                abort = 0;
                fdok = 1;
                for (int i = 0; i < nb && !abort; i++) begin
                    lvl = bits[i];
                    for (int c = 0; c < CPB && !abort; c++) begin
                        if (i != 0 || c != 0) @(negedge clk);
                        if (rst_v[g]) abort = 1;
                        else begin
                            if (txd[g] !== bits[i] && lvl === bits[i]) lvl = txd[g];
                            if (fdone[g] !== (i == nb - 1 && c == CPB - 1)) fdok = 0;
                        end
                    end
                    if (!abort) chk($sformatf("dut%0d byte %02h bit %0d txd", g, it.d, i), lvl, bits[i]);
                end
                if (!abort) chk($sformatf("dut%0d byte %02h frame_done timing", g, it.d), fdok, 1);
                gap = 0;
            end
        end
    end

    task automatic push(input int g, input logic [7:0] d, input logic p, input int gap);
        item_t it;
        it.d = d;
        it.p = p;
        it.gap = gap;
        fq[g].push_back(d);
        exp_q[g].push_back(it);
    endtask

    task automatic wait_fd(input int g, input int n);
        int k = 0;
        while (fd_cnt[g] < n && k < 500) begin @(negedge clk); k++; end
        chk($sformatf("dut%0d frames completed", g), fd_cnt[g], n);
    endtask

    task automatic wait_rd(input int g);
        int k = 0;
        while (rd_w[g] !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        chk($sformatf("dut%0d fifo_rd seen", g), rd_w[g], 1);
    endtask

    task automatic chk_idle(input int g, input string tag);
        chk({tag, " txd"}, txd[g], 1);
        chk({tag, " busy"}, busy[g], 0);
        chk({tag, " fifo_rd"}, rd_w[g], 0);
        chk({tag, " frame_done"}, fdone[g], 0);
    endtask

    initial begin
        rst_v[0] = 1; rst_v[1] = 1; en[0] = 0; en[1] = 0; mon_on = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle(0, "reset dut0");
        chk_idle(1, "reset dut1");
        @(posedge clk); #1;
        rst_v[0] = 0; rst_v[1] = 0; mon_on = 1;

        push(0, 8'hA5, 1'b0, -1);
        en[0] = 1;
        wait_fd(0, 1);
        chk("dut0 reads for A5", rd_cnt[0], 1);

        push(1, 8'h07, 1'b1, -1);
        push(1, 8'h03, 1'b0, 3);
        en[1] = 1;
        wait_fd(1, 2);
        chk("dut1 reads for parity pair", rd_cnt[1], 2);

        push(0, 8'h01, 1'b0, -1);
        push(0, 8'h80, 1'b0, 3);
        push(0, 8'hFF, 1'b0, 3);
        wait_fd(0, 4);
        chk("dut0 reads after back-to-back", rd_cnt[0], 4);
        repeat (2) @(negedge clk);
        chk("dut0 busy after back-to-back", busy[0], 0);

        push(0, 8'h11, 1'b0, -1);
        push(0, 8'h22, 1'b0, -1);
        wait_rd(0);
        repeat (12) @(posedge clk);
        #1 en[0] = 0;
        wait_fd(0, 5);
        repeat (20) @(negedge clk);
        chk("dut0 reads while disabled", rd_cnt[0], 5);
        chk("dut0 busy while disabled", busy[0], 0);
        en[0] = 1;
        wait_fd(0, 6);
        chk("dut0 reads after re-enable", rd_cnt[0], 6);

        push(0, 8'h3C, 1'b0, -1);
        push(0, 8'h5A, 1'b0, -1);
        wait_rd(0);
        repeat (19) @(posedge clk);
        #1 rst_v[0] = 1;
        @(negedge clk);
        @(negedge clk);
        chk_idle(0, "mid-frame reset dut0");
        @(posedge clk);
        #1 rst_v[0] = 0;
        chk("dut0 frame_done count after abort", fd_cnt[0], 6);
        wait_fd(0, 7);
        chk("dut0 reads after restart", rd_cnt[0], 8);

        chk("dut0 scoreboard drained", exp_q[0].size(), 0);
        chk("dut1 scoreboard drained", exp_q[1].size(), 0);
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (legal range 2..65535).
REQ-002 The block SHALL have parameter PARITY_EN, default 0, where 1 inserts an even-parity bit after the data bits.
REQ-003 The block SHALL have port clk, input, 1, system clock; all logic rising-edge.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-005 The block SHALL have port enable, input, 1, permits starting new frames.
REQ-006 The block SHALL have port fifo_empty_n, input, 1, upstream FIFO not-empty, active-low empty.
REQ-007 The block SHALL have port fifo_data, input, 8, upstream FIFO registered read data.
REQ-008 The block SHALL have port fifo_rd, output, 1, one-cycle read strobe to the FIFO.
REQ-009 The block SHALL have port txd, output, 1, serial line, idle high.
REQ-010 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 The block SHALL have port frame_done, output, 1, one-cycle pulse at the end of the stop bit.

Function
REQ-012 The FSM SHALL use states IDLE, RD, WAIT, START, DATA, PARITY, STOP; all outputs SHALL be registered.
REQ-013 IDLE->RD SHALL occur when enable=1 and fifo_empty_n=1; otherwise the FSM stays in IDLE.
REQ-014 fifo_rd SHALL be 1 only during RD, exactly one cycle per frame; RD->WAIT is unconditional.
REQ-015 In WAIT, fifo_data SHALL be captured into an 8-bit shift register at the end of the cycle; WAIT->START follows.
REQ-016 txd SHALL be 1 in IDLE, RD, WAIT and STOP, and 0 in START.
REQ-017 START, each DATA bit, PARITY and STOP SHALL each last exactly CLKS_PER_BIT cycles, timed by a bit counter that reloads at every bit boundary.
REQ-018 DATA SHALL send 8 bits LSB first; a 3-bit index SHALL advance each bit period, and DATA SHALL exit after index 7.
REQ-019 DATA->PARITY SHALL occur if PARITY_EN=1, else DATA->STOP; the parity bit SHALL be the XOR of the 8 captured bits.
REQ-020 On the last STOP cycle, frame_done SHALL pulse and the FSM SHALL return to IDLE; back-to-back frames therefore SHALL have exactly 3 idle-high cycles (IDLE, RD, WAIT) between stop and start.
REQ-021 enable deasserting mid-frame SHALL NOT abort the frame; it only blocks the next IDLE->RD transition.
REQ-022 The FSM SHALL never assert fifo_rd while fifo_empty_n=0, so an empty FIFO is never read.
REQ-023 Illegal state encodings SHALL return to IDLE on the next cycle.

Reset
REQ-024 On rst=1, the next edge SHALL set state=IDLE, txd=1, fifo_rd=0, busy=0, frame_done=0, and clear the bit counter, bit index and shift register.
REQ-025 rst asserted mid-frame SHALL abort the frame at once, with no frame_done pulse and no further fifo_rd.
REQ-026 rst SHALL take precedence over every other input.

Structure
REQ-027 A shared package SHALL hold the state enumeration, the CLKS_PER_BIT default and the data width constant (8).
REQ-028 One sub-module, uart_bit_timer, SHALL hold the bit-period down-counter, with load and tick outputs.
REQ-029 The data path SHALL consist of one shift register, one 3-bit index and one parity register.

Verification
REQ-030 Reset check: rst held 2 cycles -> txd=1, busy=0, fifo_rd=0, frame_done=0.
REQ-031 Single byte: CLKS_PER_BIT=4, PARITY_EN=0, FIFO holds 0xA5 -> one fifo_rd pulse; txd = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; one frame_done pulse.
REQ-032 Parity: PARITY_EN=1, byte 0x07 -> parity bit 1; byte 0x03 -> parity bit 0; frame length 11 bit periods.
REQ-033 Back-to-back: bytes 0x01, 0x80, 0xFF queued -> exactly 3 fifo_rd pulses, 3 frames in order, 3 high cycles between frames, then IDLE with busy=0.
REQ-034 Enable drop: enable=0 during DATA of frame 1 with 2 bytes queued -> frame 1 completes, no second fifo_rd until enable=1.
REQ-035 Mid-frame reset: rst during DATA bit 3 -> txd=1 and busy=0 on the next cycle, no frame_done pulse, and transmission restarts with a fresh fifo_rd after rst is released.
